// File: rtl/mmio_io_responder_if.sv
// -----------------------------------------------------------------------------
// mmio_io_responder_if
// CPU data-bus bundle seen by the MMIO I/O responder.
//   addr   bus address, sampled every cycle
//   we     write strobe, qualified by addr
//   din    write data
//   rdata  registered read data returned by the responder
//   hit    registered; 1 when the previous-cycle addr fell in the I/O window
// Modports: master (CPU side) drives addr/we/din; slave (responder) drives
// rdata/hit.
// -----------------------------------------------------------------------------
interface mmio_io_responder_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [7:0]        din;
   logic [7:0]        rdata;
   logic              hit;

   modport master (output addr, we, din, input rdata, hit);
   modport slave  (input addr, we, din, output rdata, hit);
endinterface

// File: rtl/mmio_io_responder.sv
// -----------------------------------------------------------------------------
// mmio_io_responder
// Memory-mapped I/O responder on the CPU data bus. Decodes a 4-byte window at
// BASE_ADDR holding MASK (+0, RW), PEND (+1, R / write-1-to-clear), debounced
// switches (+2, R) and the LED register (+3, W). The 8 switches are
// synchronised, debounced as a whole vector, and every accepted change sets
// the matching PEND bits; irq = |(PEND & MASK).
//
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active-low
//   bus    slave side of mmio_io_responder_if (addr/we/din in, rdata/hit out)
//   SW     raw asynchronous switches
//   LEDR   LED register
//   irq    level interrupt request, active-high
//
// Build option: define MMIO_LED_READBACK_EN to make a read at +3 return the
// current LEDR; otherwise that read returns 0x00 (hit still asserted).
// -----------------------------------------------------------------------------
module mmio_io_responder #(
   parameter int ADDR_W          = 16,
   parameter int BASE_ADDR       = 996,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mmio_io_responder_if.slave     bus,
   input  logic [7:0]             SW,
   output logic [7:0]             LEDR,
   output logic                   irq
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // ---------------- address decode ----------------
   // Unsigned subtraction: addresses below the base wrap to large values,
   // so a single compare covers both window edges.
   logic [ADDR_W-1:0] offset;
   logic              in_window;
   logic [1:0]        reg_sel;
   logic              wr_mask, wr_pend, wr_led;

   assign offset    = bus.addr - ADDR_W'(BASE_ADDR);
   assign in_window = (offset < ADDR_W'(4));
   assign reg_sel   = offset[1:0];
   assign wr_mask   = bus.we && in_window && (reg_sel == 2'd0);
   assign wr_pend   = bus.we && in_window && (reg_sel == 2'd1);
   assign wr_led    = bus.we && in_window && (reg_sel == 2'd3);

   // ---------------- state ----------------
   logic [1:0][7:0]  sync_reg;
   logic [7:0]       cand_reg, cand_next;
   logic [7:0]       deb_reg,  deb_next;
   logic [CW-1:0]    cnt_reg,  cnt_next;
   logic [7:0]       pend_reg, pend_next;
   logic [7:0]       mask_reg;
   logic [7:0]       led_reg;
   logic [7:0]       rdata_reg, rdata_next;
   logic             hit_reg;
   logic             accept;
   logic [7:0]       event_bits;
   logic [7:0]       w1c_bits;
   logic [7:0]       sw_sync;

   assign sw_sync = sync_reg[1];

   // ---------------- debounce ----------------
   always_comb begin
      cand_next = cand_reg;
      deb_next  = deb_reg;
      cnt_next  = cnt_reg;
      accept    = 1'b0;
      if (sw_sync != cand_reg) begin
         // any bounce restarts the stability count
         cand_next = sw_sync;
         cnt_next  = '0;
      end else if (cand_reg != deb_reg) begin
         if (cnt_reg == CNT_LAST) begin
            deb_next = cand_reg;
            cnt_next = '0;
            accept   = 1'b1;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end else begin
         cnt_next = '0;
      end
   end

   assign event_bits = accept  ? (cand_reg ^ deb_reg) : 8'h00;
   assign w1c_bits   = wr_pend ? bus.din              : 8'h00;

   // A debounce event setting a bit beats a same-cycle W1C of that bit.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pend
         assign pend_next[gi] = event_bits[gi] | (pend_reg[gi] & ~w1c_bits[gi]);
      end
   endgenerate

   // ---------------- read mux (pre-write values) ----------------
   always_comb begin
      rdata_next = 8'h00;
      if (in_window) begin
         case (reg_sel)
            2'd0:    rdata_next = mask_reg;
            2'd1:    rdata_next = pend_reg;
            2'd2:    rdata_next = deb_reg;
`ifdef MMIO_LED_READBACK_EN
            default: rdata_next = led_reg;
`else
            default: rdata_next = 8'h00;
`endif
         endcase
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg  <= '0;
         cand_reg  <= 8'h00;
         deb_reg   <= 8'h00;
         cnt_reg   <= '0;
         pend_reg  <= 8'h00;
         mask_reg  <= 8'h00;
         led_reg   <= 8'h00;
         rdata_reg <= 8'h00;
         hit_reg   <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], SW};
         cand_reg  <= cand_next;
         deb_reg   <= deb_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         if (wr_mask) mask_reg <= bus.din;
         if (wr_led)  led_reg  <= bus.din;
         rdata_reg <= rdata_next;
         hit_reg   <= in_window;
      end
   end

   assign bus.rdata = rdata_reg;
   assign bus.hit   = hit_reg;
   assign LEDR      = led_reg;
   assign irq       = |(pend_reg & mask_reg);

endmodule

// File: tb/tb_mmio_io_responder.sv
// -----------------------------------------------------------------------------
// tb_mmio_io_responder
// Directed bench for mmio_io_responder with DEBOUNCE_CYCLES=4, BASE_ADDR=996.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Debounce timing: a SW change applied after edge 0 reaches sync[1] at edge 2,
// cand at edge 3, and deb/PEND at edge 3+4 = 7. A read of deb issued at that
// edge still sees the old value; the new value appears on rdata one edge later.
// -----------------------------------------------------------------------------
module tb_mmio_io_responder;

   logic       clk;
   logic       rst_n;
   logic [7:0] SW;
   logic [7:0] LEDR;
   logic       irq;

   int n_vec  = 0;
   int n_miss = 0;

`ifdef MMIO_LED_READBACK_EN
   localparam logic [7:0] LED_RB = 8'h3C;
`else
   localparam logic [7:0] LED_RB = 8'h00;
`endif

   mmio_io_responder_if #(.ADDR_W(16)) bus ();

   mmio_io_responder #(
      .ADDR_W          (16),
      .BASE_ADDR       (996),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .SW    (SW),
      .LEDR  (LEDR),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("vec %0d %s: 0x%0h ok", n_vec, tag, got);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      bus.addr = a;
      bus.din  = d;
      bus.we   = 1'b1;
      tick;
      bus.we   = 1'b0;
      bus.addr = 16'd0;
      bus.din  = 8'h00;
   endtask

   task automatic do_read(input logic [15:0] a, output logic [7:0] d, output logic h);
      bus.addr = a;
      bus.we   = 1'b0;
      tick;
      d = bus.rdata;
      h = bus.hit;
      bus.addr = 16'd0;
   endtask

   logic [7:0] rd;
   logic       rh;

   initial begin
      // ---- 1: reset with switches at 0xA5 ----
      SW = 8'hA5; rst_n = 1'b0;
      bus.addr = 16'd0; bus.we = 1'b0; bus.din = 8'h00;
      tick; tick;
      check_vec("rst_ledr",  LEDR, 8'h00);
      check_vec("rst_irq",   irq, 1'b0);
      check_vec("rst_rdata", bus.rdata, 8'h00);
      check_vec("rst_hit",   bus.hit, 1'b0);
      rst_n = 1'b1;
      bus.addr = 16'd998;
      for (int e = 1; e <= 8; e++) begin
         tick;
         if (e == 7) begin
            check_vec("deb_e7_rdata", bus.rdata, 8'h00);
            check_vec("deb_e7_hit",   bus.hit, 1'b1);
         end
         if (e == 8) check_vec("deb_e8_rdata", bus.rdata, 8'hA5);
      end
      bus.addr = 16'd0;
      check_vec("t1_irq_masked", irq, 1'b0);
      do_read(16'd997, rd, rh);
      check_vec("t1_pend", rd, 8'hA5);
      do_write(16'd997, 8'hA5);
      do_read(16'd997, rd, rh);
      check_vec("t1_pend_clr", rd, 8'h00);

      // ---- 2: LED write / readback ----
      do_write(16'd999, 8'h3C);
      check_vec("t2_ledr", LEDR, 8'h3C);
      do_read(16'd999, rd, rh);
      check_vec("t2_led_read", rd, LED_RB);
      check_vec("t2_led_hit",  rh, 1'b1);

      // ---- 3: masked interrupt ----
      SW = 8'h00;
      for (int i = 0; i < 10; i++) tick;
      do_write(16'd997, 8'hFF);
      bus.addr = 16'd996; bus.din = 8'h01; bus.we = 1'b1;
      tick;  // same-cycle read returns pre-write MASK
      check_vec("t3_mask_prewrite", bus.rdata, 8'h00);
      bus.we = 1'b0; bus.addr = 16'd0;
      do_read(16'd996, rd, rh);
      check_vec("t3_mask", rd, 8'h01);
      check_vec("t3_irq_idle", irq, 1'b0);
      SW = 8'h01;
      for (int e = 1; e <= 7; e++) begin
         tick;
         if (e == 6) check_vec("t3_irq_e6", irq, 1'b0);
         if (e == 7) check_vec("t3_irq_e7", irq, 1'b1);
      end
      do_write(16'd997, 8'h01);
      check_vec("t3_irq_cleared", irq, 1'b0);
      do_read(16'd997, rd, rh);
      check_vec("t3_pend_clr", rd, 8'h00);

      // ---- 4: bouncing switch never accepted ----
      SW = 8'h00;
      for (int i = 0; i < 10; i++) tick;
      do_write(16'd997, 8'hFF);
      for (int i = 0; i < 10; i++) begin
         SW = (i % 2 == 0) ? 8'h10 : 8'h00;
         tick; tick;
      end
      SW = 8'h00;
      for (int i = 0; i < 10; i++) tick;
      do_read(16'd998, rd, rh);
      check_vec("t4_deb", rd, 8'h00);
      do_read(16'd997, rd, rh);
      check_vec("t4_pend", rd, 8'h00);

      // ---- 5: debounce set beats same-cycle W1C ----
      SW = 8'h02;
      for (int i = 0; i < 6; i++) tick;
      bus.addr = 16'd997; bus.din = 8'h02; bus.we = 1'b1;
      tick;  // edge 7: debounce accepts 0x02
      bus.we = 1'b0; bus.addr = 16'd0; bus.din = 8'h00;
      do_read(16'd997, rd, rh);
      check_vec("t5_pend_set_wins", rd, 8'h02);
      check_vec("t5_irq_unmasked_bit", irq, 1'b0);

      // ---- 6: out-of-window writes, then reset mid-debounce ----
      do_write(16'd995, 8'hFF);
      check_vec("t6_oow_rdata", bus.rdata, 8'h00);
      check_vec("t6_oow_hit",   bus.hit, 1'b0);
      check_vec("t6_oow_ledr",  LEDR, 8'h3C);
      do_write(16'd1000, 8'hFF);
      check_vec("t6_high_hit",  bus.hit, 1'b0);
      do_read(16'd996, rd, rh);
      check_vec("t6_mask_kept", rd, 8'h01);
      do_read(16'd997, rd, rh);
      check_vec("t6_pend_kept", rd, 8'h02);
      SW = 8'h40;
      for (int i = 0; i < 4; i++) tick;
      rst_n = 1'b0; bus.addr = 16'd999; bus.din = 8'hFF; bus.we = 1'b1;
      tick;  // reset overrides the LED write
      check_vec("t6_rst_ledr",  LEDR, 8'h00);
      check_vec("t6_rst_rdata", bus.rdata, 8'h00);
      check_vec("t6_rst_hit",   bus.hit, 1'b0);
      rst_n = 1'b1; bus.we = 1'b0; bus.addr = 16'd0; bus.din = 8'h00;
      do_read(16'd996, rd, rh);
      check_vec("t6_rst_mask", rd, 8'h00);
      do_read(16'd997, rd, rh);
      check_vec("t6_rst_pend", rd, 8'h00);
      do_read(16'd998, rd, rh);
      check_vec("t6_rst_deb", rd, 8'h00);
      check_vec("t6_rst_irq", irq, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
